// File: rtl/row_column_reader_if.sv
// Bank read bus and column stream between row_column_reader and its neighbours.
// master = the reader side; slave = banks plus downstream consumer.
interface row_column_reader_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 10,
  parameter int ROWS  = 3
);
  logic                  re;
  logic [AW-1:0]         addr;
  logic [ROWS*WIDTH-1:0] bank_data;
  logic                  col_valid;
  logic                  col_ready;
  logic [ROWS*WIDTH-1:0] col_data;

  modport master (
    output re, addr, col_valid, col_data,
    input  bank_data, col_ready
  );

  modport slave (
    input  re, addr, col_valid, col_data,
    output bank_data, col_ready
  );
endinterface

// File: rtl/row_column_reader.sv
// Reads one line from ROWS row banks in lockstep and streams rotated vertical columns,
// hiding the banks' 1-cycle read latency behind a 2-entry skid FIFO with credit-based issue.
module row_column_reader #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 640,
  parameter int ROWS   = 3,
  parameter int LINE_W = 640
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [$clog2(ROWS)-1:0] i_base_row,
  output logic                    o_busy,
  output logic                    o_done,
  row_column_reader_if.master     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(ROWS);
  localparam int CW = $clog2(LINE_W + 1);
  localparam int DW = ROWS * WIDTH;

  localparam logic [AW-1:0] LAST_ADDR = AW'(LINE_W - 1);
  localparam logic [CW-1:0] LINE_CNT  = CW'(LINE_W);
  localparam logic [BW:0]   ROWS_W    = (BW + 1)'(ROWS);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   base_q, base_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   col_count_q, col_count_d;
  logic            inflight_q;
  logic            re_c, done_c, start_acc, credit, xfer;

  logic [DW-1:0]   fifo_mem_q [0:1];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      fifo_count_q, fifo_count_d;
  logic            fifo_empty, push, pop;
  logic [DW-1:0]   rot_data;

  // Rotation: slice k comes from bank (base+k) mod ROWS, reduced without wrapping past ROWS-1.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_rot
    logic [BW:0] sum, sel;
    assign sum = {1'b0, base_q} + (BW + 1)'(gi);
    assign sel = (sum >= ROWS_W) ? (sum - ROWS_W) : sum;
    assign rot_data[gi*WIDTH +: WIDTH] = bus.bank_data[sel*WIDTH +: WIDTH];
  end

  assign fifo_empty = (fifo_count_q == 2'd0);
  // Empty FIFO bypass keeps first-column latency at two cycles after start.
  assign bus.col_valid = !fifo_empty || inflight_q;
  assign bus.col_data  = !fifo_empty ? fifo_mem_q[rd_ptr_q]
                       : (inflight_q ? rot_data : '0);
  assign xfer = bus.col_valid && bus.col_ready;
  assign pop  = !fifo_empty && bus.col_ready;
  assign push = inflight_q && !(fifo_empty && bus.col_ready);

  assign credit    = (fifo_count_q == 2'd0) || ((fifo_count_q == 2'd1) && !inflight_q);
  assign done_c    = (state_q == S_DRAIN) && (col_count_q == LINE_CNT);
  assign o_busy    = (state_q != S_IDLE) && !done_c;
  assign o_done    = done_c;
  assign start_acc = i_start && !o_busy;

  assign bus.re   = re_c;
  assign bus.addr = re_c ? rd_addr_q : addr_q;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    rd_addr_d    = rd_addr_q;
    addr_d       = addr_q;
    col_count_d  = col_count_q;
    re_c         = 1'b0;
    fifo_count_d = fifo_count_q;

    if (xfer) col_count_d = col_count_q + CW'(1);

    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + 2'd1;
      2'b01:   fifo_count_d = fifo_count_q - 2'd1;
      default: fifo_count_d = fifo_count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d     = S_READ;
          base_d      = i_base_row;
          rd_addr_d   = '0;
          col_count_d = '0;
        end
      end
      S_READ: begin
        if (credit) begin
          re_c   = 1'b1;
          addr_d = rd_addr_q;
          if (rd_addr_q == LAST_ADDR) state_d = S_DRAIN;
          else                        rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (done_c) begin
          if (start_acc) begin
            state_d     = S_READ;
            base_d      = i_base_row;
            rd_addr_d   = '0;
            col_count_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      rd_addr_q    <= '0;
      addr_q       <= '0;
      col_count_q  <= '0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      rd_addr_q    <= rd_addr_d;
      addr_q       <= addr_d;
      col_count_q  <= col_count_d;
      inflight_q   <= re_c;
      fifo_count_q <= fifo_count_d;
      if (push) wr_ptr_q <= !wr_ptr_q;
      if (pop)  rd_ptr_q <= !rd_ptr_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= rot_data;
  end

  a_base_row_legal: assert property (@(posedge i_clk) disable iff (i_rst)
    start_acc |-> ({1'b0, i_base_row} < ROWS_W));

endmodule
